pattern_sequencer: RTL
======================

# pattern_sequencer

Multi-channel, run-time-loadable blink-pattern sequencer for the TinyFPGA BX LED/GPIO outputs. It generalises the fixed 32-bit, fixed-rate LED blinker in four ways: each channel gets its own pattern, length and mode; the step rate is programmable; a one-shot mode signals completion; and optional PWM dimming is available. It sits between the top-level control logic and the LED/PIN pads, and is clocked from the 16 MHz CLK.

## Interface
- CHANNELS, 2, number of independent output channels (1..16)
- PAT_LEN, 32, pattern storage bits per channel; power of two, 2..64
- DIV_W, 24, width of step-divider input

- CLK  in  1  system clock, 16 MHz; all logic on rising edge
- RST_N  in  1  asynchronous active-low reset; deassertion synchronous to CLK externally
- STEP_DIV  in  DIV_W  step period minus one, in CLK cycles; sampled live
- LOAD_VALID  in  1  load request
- LOAD_READY  out  1  always 1 out of reset; 0 while RST_N low
- LOAD_CH  in  clog2(CHANNELS) (min 1)  target channel
- LOAD_PATTERN  in  PAT_LEN  pattern; bit 0 is played first
- LOAD_LAST  in  clog2(PAT_LEN)  index of last step played
- LOAD_REPEAT  in  1  1 = loop forever, 0 = one-shot
- STOP  in  CHANNELS  per-channel stop request
- OUT  out  CHANNELS  pattern outputs to LED/pins
- BUSY  out  CHANNELS  channel in RUN state
- DONE  out  CHANNELS  one-cycle pulse when a one-shot finishes

## Operation
- Prescaler: shared free-running counter pre. When pre >= STEP_DIV, tick=1 and pre<=0; otherwise pre<=pre+1. STEP_DIV=0 gives a tick every cycle. The prescaler is never restarted by loads.
- Per channel: pat[PAT_LEN], last, repeat, idx, state ∈ {IDLE, RUN}.
- Load is accepted on an edge with LOAD_VALID=1 and LOAD_CH<CHANNELS. It writes pat/last/repeat, sets idx<=0 and state<=RUN. A load with LOAD_CH>=CHANNELS is silently dropped.
- RUN on a tick:
  - idx<last: idx<=idx+1.
  - idx==last with repeat=1: idx<=0 (wrap).
  - idx==last with repeat=0: state<=IDLE and DONE pulses for exactly one cycle.
- last=0 with repeat=1: holds pat[0] indefinitely. last=0 one-shot: finishes on the first tick.
- STOP[c]=1: state<=IDLE and idx<=0 on the next edge, with no DONE.
- Priority per channel, per edge: STOP > load > tick. A load on a tick edge starts at idx 0 and ignores the tick. STOP together with a load to the same channel leaves the channel IDLE.
- OUT[c] = (state==RUN) & pat[idx]. It is decoded from flops only, with no combinational path from any input.
- BUSY[c] = (state==RUN).
- Reloading a running channel restarts it immediately and produces no DONE for the aborted run.

## Timing
- Reset values: pre=0, all state=IDLE, idx=0, pat=0, OUT=0, BUSY=0, DONE=0, LOAD_READY=0.
- Reset asserted mid-run: outputs go to their reset values asynchronously; any pending DONE is lost.
- Load accepted at edge k: BUSY=1 and OUT=pat[0] after edge k.
- First step duration is 1..STEP_DIV+1 cycles, depending on prescaler phase. Every later step is exactly STEP_DIV+1 cycles.
- DONE asserts after the edge that retires the last step and deasserts after the next edge. BUSY falls on the same edge DONE rises.
- STEP_DIV reduced below the current pre: tick on the next edge, then the new period applies.

## Configuration
- SEQ_PWM_EN defined:
  - Adds input LOAD_DUTY [7:0], stored per channel on load, plus a shared free-running 8-bit counter pwm (reset 0, wraps 255→0).
  - OUT[c] = RUN & pat[idx] & (pwm < duty[c]).
  - duty=0 forces OUT low. duty=255 gives 255/256 on-time.
- SEQ_PWM_EN undefined: no LOAD_DUTY port, no pwm counter; OUT as in Operation.

## Test plan
- Reset: hold RST_N=0, then release. OUT=0, BUSY=0, DONE=0, LOAD_READY=0 during reset, then 1 on the first edge after release.
- Repeat mode with STEP_DIV=3: load ch0 with 32'h0000_0005, last=3, repeat=1. OUT[0] follows 1,0,1,0 with steps of 4 cycles from the 2nd step on, and wraps to idx 0 with no DONE over 3 periods.
- One-shot with STEP_DIV=0: load ch1 with pattern 4'b1011, last=3, repeat=0. OUT[1]=1,1,0,1 on consecutive cycles. DONE[1] pulses exactly once, coincident with BUSY[1] falling; OUT[1]=0 afterwards.
- Collisions:
  - STOP[0] together with a load to ch0 leaves the channel IDLE.
  - A load on a tick edge restarts at idx 0.
  - LOAD_CH=2 with CHANNELS=2 changes nothing.
- Reset mid-run: assert RST_N=0 while ch0 is running and a one-shot on ch1 is at its last step. All outputs drop to 0 asynchronously and no DONE follows.
- With SEQ_PWM_EN defined: pattern all ones, duty=64, STEP_DIV=0. OUT is high for exactly 64 of every 256 cycles. duty=0 keeps OUT at 0.

Source files
------------

// File: rtl/pattern_sequencer.sv
// Multi-channel run-time-loadable blink-pattern sequencer with a shared step prescaler.
// Optional PWM dimming is compiled in when SEQ_PWM_EN is defined.
module pattern_sequencer #(
    parameter int CHANNELS = 2,
    parameter int PAT_LEN  = 32,
    parameter int DIV_W    = 24,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int IDX_W   = $clog2(PAT_LEN)
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [DIV_W-1:0]    STEP_DIV,
    input  logic                LOAD_VALID,
    output logic                LOAD_READY,
    input  logic [CH_W-1:0]     LOAD_CH,
    input  logic [PAT_LEN-1:0]  LOAD_PATTERN,
    input  logic [IDX_W-1:0]    LOAD_LAST,
    input  logic                LOAD_REPEAT,
`ifdef SEQ_PWM_EN
    input  logic [7:0]          LOAD_DUTY,
`endif
    input  logic [CHANNELS-1:0] STOP,
    output logic [CHANNELS-1:0] OUT,
    output logic [CHANNELS-1:0] BUSY,
    output logic [CHANNELS-1:0] DONE
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic [DIV_W-1:0]    pre_r;
    logic [DIV_W-1:0]    pre_nxt_s;
    logic                tick_s;
    logic                ready_r;

    state_t              state_r     [CHANNELS];
    state_t              state_nxt_s [CHANNELS];
    logic [PAT_LEN-1:0]  pat_r       [CHANNELS];
    logic [PAT_LEN-1:0]  pat_nxt_s   [CHANNELS];
    logic [IDX_W-1:0]    idx_r       [CHANNELS];
    logic [IDX_W-1:0]    idx_nxt_s   [CHANNELS];
    logic [IDX_W-1:0]    last_r      [CHANNELS];
    logic [IDX_W-1:0]    last_nxt_s  [CHANNELS];
    logic [CHANNELS-1:0] rep_r;
    logic [CHANNELS-1:0] rep_nxt_s;
    logic [CHANNELS-1:0] out_r;
    logic [CHANNELS-1:0] out_nxt_s;
    logic [CHANNELS-1:0] done_r;
    logic [CHANNELS-1:0] done_nxt_s;
    logic [CHANNELS-1:0] busy_s;

`ifdef SEQ_PWM_EN
    logic [7:0]          pwm_r;
    logic [7:0]          pwm_nxt_s;
    logic [7:0]          duty_r      [CHANNELS];
    logic [7:0]          duty_nxt_s  [CHANNELS];
`endif

    // Shared prescaler: a shrinking STEP_DIV below pre still ticks on the next edge.
    always_comb begin
        tick_s    = 1'b0;
        pre_nxt_s = pre_r;
        if (pre_r >= STEP_DIV) begin
            tick_s    = 1'b1;
            pre_nxt_s = {DIV_W{1'b0}};
        end else begin
            tick_s    = 1'b0;
            pre_nxt_s = pre_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef SEQ_PWM_EN
    // Free-running dimming counter, wraps 255 to 0.
    always_comb begin
        pwm_nxt_s = pwm_r + 8'd1;
    end
`endif

    // Per-channel next state; STOP beats load, load beats tick.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            state_nxt_s[c] = state_r[c];
            pat_nxt_s[c]   = pat_r[c];
            idx_nxt_s[c]   = idx_r[c];
            last_nxt_s[c]  = last_r[c];
            rep_nxt_s[c]   = rep_r[c];
            done_nxt_s[c]  = 1'b0;
`ifdef SEQ_PWM_EN
            duty_nxt_s[c]  = duty_r[c];
`endif
            if (STOP[c]) begin
                state_nxt_s[c] = IDLE;
                idx_nxt_s[c]   = {IDX_W{1'b0}};
            end else if (LOAD_VALID && (LOAD_CH == CH_W'(c))) begin
                state_nxt_s[c] = RUN;
                pat_nxt_s[c]   = LOAD_PATTERN;
                idx_nxt_s[c]   = {IDX_W{1'b0}};
                last_nxt_s[c]  = LOAD_LAST;
                rep_nxt_s[c]   = LOAD_REPEAT;
`ifdef SEQ_PWM_EN
                duty_nxt_s[c]  = LOAD_DUTY;
`endif
            end else if (tick_s) begin
                case (state_r[c])
                    RUN: begin
                        if (idx_r[c] != last_r[c]) begin
                            idx_nxt_s[c] = idx_r[c] + {{(IDX_W-1){1'b0}}, 1'b1};
                        end else if (rep_r[c]) begin
                            idx_nxt_s[c] = {IDX_W{1'b0}};
                        end else begin
                            state_nxt_s[c] = IDLE;
                            done_nxt_s[c]  = 1'b1;
                        end
                    end
                    IDLE: begin
                        state_nxt_s[c] = IDLE;
                    end
                    default: begin
                        state_nxt_s[c] = IDLE;
                    end
                endcase
            end else begin
                state_nxt_s[c] = state_r[c];
            end
        end
    end

    // OUT is registered from next-state values so it matches the decode of the flops after each edge.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
`ifdef SEQ_PWM_EN
            out_nxt_s[c] = (state_nxt_s[c] == RUN) & pat_nxt_s[c][idx_nxt_s[c]]
                           & (pwm_nxt_s < duty_nxt_s[c]);
`else
            out_nxt_s[c] = (state_nxt_s[c] == RUN) & pat_nxt_s[c][idx_nxt_s[c]];
`endif
            busy_s[c]    = (state_r[c] == RUN);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pre_r   <= {DIV_W{1'b0}};
            ready_r <= 1'b0;
            rep_r   <= {CHANNELS{1'b0}};
            out_r   <= {CHANNELS{1'b0}};
            done_r  <= {CHANNELS{1'b0}};
            for (int c = 0; c < CHANNELS; c++) begin
                state_r[c] <= IDLE;
                pat_r[c]   <= {PAT_LEN{1'b0}};
                idx_r[c]   <= {IDX_W{1'b0}};
                last_r[c]  <= {IDX_W{1'b0}};
`ifdef SEQ_PWM_EN
                duty_r[c]  <= 8'd0;
`endif
            end
`ifdef SEQ_PWM_EN
            pwm_r   <= 8'd0;
`endif
        end else begin
            pre_r   <= pre_nxt_s;
            ready_r <= 1'b1;
            rep_r   <= rep_nxt_s;
            out_r   <= out_nxt_s;
            done_r  <= done_nxt_s;
            for (int c = 0; c < CHANNELS; c++) begin
                state_r[c] <= state_nxt_s[c];
                pat_r[c]   <= pat_nxt_s[c];
                idx_r[c]   <= idx_nxt_s[c];
                last_r[c]  <= last_nxt_s[c];
`ifdef SEQ_PWM_EN
                duty_r[c]  <= duty_nxt_s[c];
`endif
            end
`ifdef SEQ_PWM_EN
            pwm_r   <= pwm_nxt_s;
`endif
        end
    end

    assign LOAD_READY = ready_r;
    assign OUT        = out_r;
    assign BUSY       = busy_s;
    assign DONE       = done_r;

endmodule
